mac_dot_acc: RTL and testbench

- Parametrised successor to the fixed 4-lane, 16-bit multiply-accumulate unit.
- Computes the signed dot product of LANES input-feature/weight pairs per beat and accumulates it over a multi-beat frame delimited by in_last.
- Emits one rescaled, saturated result per frame, with a valid pulse and a saturation flag.
- Sits between the feature/weight fetch logic and the output-feature-map writer in the convolution datapath.

---
 rtl/mac_dot_acc.sv | 137 +++++++++++++
 tb/tb_mac_dot_acc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mac_dot_acc.sv
// Multi-lane signed dot-product MAC: products, adder tree, then frame accumulation
// with arithmetic rescale and saturation. One result pulse per in_last-delimited frame.

module mac_dot_lane #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod
);
  logic [2*DATA_W-1:0] a_x, b_x;

  // Sign-extend first so the truncated 2N-bit product is the exact signed product.
  assign a_x = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_x = {{DATA_W{b[DATA_W-1]}}, b};

  always_ff @(posedge clk) begin
    if (!rst_n)  prod <= '0;
    else if (en) prod <= a_x * b_x;
  end
endmodule

module mac_dot_acc #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [LANES*DATA_W-1:0]  ifm,
  input  logic [LANES*DATA_W-1:0]  w,
  output logic [OUT_W-1:0]         result,
  output logic                     out_valid,
  output logic                     sat,
  output logic                     busy
);
  localparam int PROD_W = 2*DATA_W;
  localparam int STAGES = 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic [OUT_W-1:0] val;
    logic             sat;
  } res_t;

  logic [LANES-1:0][DATA_W-1:0] ifm_l, w_l;
  logic [LANES-1:0][PROD_W-1:0] prod;
  logic [STAGES:0]              vld_pipe, last_pipe;
  logic signed [ACC_W-1:0]      sum_c, sum_q, acc, nxt, shifted;
  logic                         part;
  res_t                         res_c, res_q;

  assign ifm_l = ifm;
  assign w_l   = w;

  // Stage 1: per-lane product registers.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_dot_lane #(.DATA_W(DATA_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (in_valid),
      .a    (ifm_l[g]),
      .b    (w_l[g]),
      .prod (prod[g])
    );
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++)
      sum_c = sum_c + ACC_W'($signed(prod[i]));
  end

  // Stage 2: summed beat. vld_pipe[0]/[1] are stage-1/stage-2 valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      sum_q     <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], in_valid};
      last_pipe <= {last_pipe[STAGES-1:0], in_valid & in_last};
      if (vld_pipe[0]) sum_q <= sum_c;
    end
  end

  assign nxt     = acc + sum_q;
  assign shifted = nxt >>> SHIFT;

  always_comb begin
    res_c.sat = 1'b0;
    res_c.val = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      res_c.sat = 1'b1;
      res_c.val = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      res_c.sat = 1'b1;
      res_c.val = SAT_MIN[OUT_W-1:0];
    end
  end

  // Stage 3: accumulate; a last beat emits the frame and restarts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      part      <= 1'b0;
      res_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (vld_pipe[1]) begin
        if (last_pipe[1]) begin
          acc       <= '0;
          part      <= 1'b0;
          res_q     <= res_c;
          out_valid <= 1'b1;
        end else begin
          acc  <= nxt;
          part <= 1'b1;
        end
      end
    end
  end

  assign result = res_q.val;
  assign sat    = res_q.sat;
  assign busy   = vld_pipe[0] | vld_pipe[1] | part;
endmodule

// File: tb/tb_mac_dot_acc.sv
// Directed bench for mac_dot_acc: frame-level model scheduled per edge, checked every
// cycle on two instances (SHIFT=0 and SHIFT=4), plus literal pins on the result sequence.

module tb_mac_dot_acc;
  localparam int LANES = 4, DW = 16, AW = 40, OW = 16, N = 256;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_last;
  logic [LANES*DW-1:0] ifm, w;
  logic [OW-1:0] result, result4;
  logic out_valid, sat, busy, out_valid4, sat4, busy4;

  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_dot_acc #(.LANES(LANES), .DATA_W(DW), .ACC_W(AW), .OUT_W(OW), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .ifm(ifm), .w(w),
    .result(result), .out_valid(out_valid), .sat(sat), .busy(busy));

  mac_dot_acc #(.LANES(LANES), .DATA_W(DW), .ACC_W(AW), .OUT_W(OW), .SHIFT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .ifm(ifm), .w(w),
    .result(result4), .out_valid(out_valid4), .sat(sat4), .busy(busy4));

  // Expected outputs after each edge index.
  bit  e_ov[N], e_rst[N], e_busy[N], e_s0[N], e_s4[N];
  int  e_v0[N], e_v4[N];
  longint fs = 0;
  bit open_f = 0, tail = 0;

  int q0[$], q4[$];
  bit qs[$];

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endtask

  function automatic void satf(input longint n, input int sh, output int v, output bit s);
    longint q;
    longint hi, lo;
    q  = n >>> sh;
    hi = (longint'(1) << (OW-1)) - 1;
    lo = -(longint'(1) << (OW-1));
    s  = 1'b0;
    v  = int'(q);
    if (q > hi) begin v = int'(hi); s = 1'b1; end
    else if (q < lo) begin v = int'(lo); s = 1'b1; end
  endfunction

  task automatic drive(input bit r, input bit v, input bit l, input int a[4], input int b[4]);
    int e;
    longint d;
    rst_n = r; in_valid = v; in_last = l;
    d = 0;
    for (int i = 0; i < LANES; i++) begin
      ifm[i*DW +: DW] = 16'(a[i]);
      w[i*DW +: DW]   = 16'(b[i]);
      d += longint'(a[i]) * longint'(b[i]);
    end
    e = cyc;
    if (!r) begin
      fs = 0; open_f = 0; tail = 0;
      e_rst[e] = 1; e_busy[e] = 0;
      for (int k = 0; k < 3; k++) e_ov[e+k] = 0;
    end else begin
      e_busy[e] = open_f | tail | v;
      tail = v & l;
      if (v) begin
        fs += d;
        open_f = !l;
        if (l) begin
          e_ov[e+2] = 1;
          satf(fs, 0, e_v0[e+2], e_s0[e+2]);
          satf(fs, 4, e_v4[e+2], e_s4[e+2]);
          fs = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1, 0, 0, '{0,0,0,0}, '{0,0,0,0});
  endtask

  // Per-cycle compare against the model, holding result between pulses.
  int  h0 = 0, h4 = 0;
  bit  hs0 = 0, hs4 = 0;
  always @(negedge clk) begin
    int e;
    e = cyc - 1;
    if (e >= 0 && e < N) begin
      if (e_rst[e]) begin h0 = 0; h4 = 0; hs0 = 0; hs4 = 0; end
      if (e_ov[e]) begin h0 = e_v0[e]; h4 = e_v4[e]; hs0 = e_s0[e]; hs4 = e_s4[e]; end
      chk("out_valid", out_valid, e_ov[e]);
      chk("out_valid_s4", out_valid4, e_ov[e]);
      chk("busy", busy, e_busy[e]);
      chk("busy_s4", busy4, e_busy[e]);
      chk("result", $signed(result), h0);
      chk("result_s4", $signed(result4), h4);
      if (e_ov[e] || e_rst[e]) begin
        chk("sat", sat, hs0);
        chk("sat_s4", sat4, hs4);
      end
      if (out_valid === 1'b1) begin
        q0.push_back(int'($signed(result)));
        q4.push_back(int'($signed(result4)));
        qs.push_back(sat);
      end
    end
  end

  int lit0[8]  = '{70, 32767, -32768, -17, 70, 10, 70, 5};
  int lit4[8]  = '{4, 3750, -2500, -2, 4, 0, 4, 0};
  bit lits[8]  = '{0, 1, 1, 0, 0, 0, 0, 0};

  initial begin
    drive(0, 0, 0, '{0,0,0,0}, '{0,0,0,0});
    drive(0, 0, 0, '{0,0,0,0}, '{0,0,0,0});
    idle(2);
    // single-beat frame, sum 70
    drive(1, 1, 1, '{1,2,3,4}, '{5,6,7,8});
    idle(4);
    // three contiguous beats, 60000 total -> positive clamp
    drive(1, 1, 0, '{100,100,100,100}, '{50,50,50,50});
    drive(1, 1, 0, '{100,100,100,100}, '{50,50,50,50});
    drive(1, 1, 1, '{100,100,100,100}, '{50,50,50,50});
    idle(4);
    // -40000 -> negative clamp
    drive(1, 1, 1, '{-1000,0,0,0}, '{40,0,0,0});
    idle(4);
    // -17: floor shift gives -2 on the SHIFT=4 instance
    drive(1, 1, 1, '{-17,0,0,0}, '{1,0,0,0});
    idle(4);
    // back-to-back single-beat frames 70 then 10
    drive(1, 1, 1, '{1,2,3,4}, '{5,6,7,8});
    drive(1, 1, 1, '{1,1,1,1}, '{1,2,3,4});
    idle(4);
    // two-beat frame with idle gap: 30 + 40
    drive(1, 1, 0, '{1,2,3,4}, '{1,2,3,4});
    idle(3);
    drive(1, 1, 1, '{10,0,0,0}, '{4,0,0,0});
    idle(4);
    // partial frame aborted by reset, then single beat of 5
    drive(1, 1, 0, '{100,0,0,0}, '{5,0,0,0});
    drive(1, 1, 0, '{100,0,0,0}, '{5,0,0,0});
    drive(0, 0, 0, '{0,0,0,0}, '{0,0,0,0});
    drive(1, 1, 1, '{5,0,0,0}, '{1,0,0,0});
    idle(5);
    #1;
    chk("pulse_count", q0.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < q0.size()) begin
        chk($sformatf("lit_result[%0d]", i), q0[i], lit0[i]);
        chk($sformatf("lit_result_s4[%0d]", i), q4[i], lit4[i]);
        chk($sformatf("lit_sat[%0d]", i), qs[i], lits[i]);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
